// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared constants and PC range check for the fetch stage
package fetch_sequencer_pkg;

    localparam logic [1:0]  FS_FETCH = 2'd0;
    localparam logic [1:0]  FS_VALID = 2'd1;
    localparam logic [1:0]  FS_FAULT = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_JAL   = 6'h03;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  FUNCT_JR = 6'h08;

    // last_word is the highest legal word address (imem size minus 4)
    function automatic logic pc_faulty(input logic [31:0] pc, input logic [31:0] last_word);
        return (pc[1:0] != 2'b00) || (pc > last_word);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// rtl/fetch_sequencer_pc_next.sv - next-PC select (jr > j/jal > branch > pc+4) and fault check
module fetch_sequencer_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [31:0] i_pc,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_imm,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_jump_reg,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_next_pc,
    output logic        o_next_fault
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;

    assign w_pc_plus4   = i_pc + 32'd4;
    assign w_branch_off = {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};

    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_jump_reg) begin
            o_next_pc = i_jr_target;
        end else if (i_jump) begin
            o_next_pc = {w_pc_plus4[31:28], i_jump_index, 2'b00};
        end else if (i_branch_taken) begin
            o_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    assign o_next_fault = pc_faulty(o_next_pc, 32'(IMEM_BYTES - 4));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner: assembles big-endian words from byte imem, hands them to the core
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic        fault
);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] w_next_pc;
    logic        w_next_fault;

    fetch_sequencer_pc_next #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_next (
        .i_pc           (r_pc),
        .i_branch_taken (branch_taken),
        .i_branch_imm   (branch_imm),
        .i_jump         (jump),
        .i_jump_index   (jump_index),
        .i_jump_reg     (jump_reg),
        .i_jr_target    (jr_target),
        .o_next_pc      (w_next_pc),
        .o_next_fault   (w_next_fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_cnt      <= 3'd0;
            r_instr    <= 32'd0;
            r_mem_addr <= RESET_PC;
            r_state    <= pc_faulty(RESET_PC, 32'(IMEM_BYTES - 4)) ? FS_FAULT : FS_FETCH;
        end else begin
            case (r_state)
                FS_FETCH: begin
                    // mem_rdata in cnt=k is the byte addressed during cnt=k-1
                    case (r_cnt)
                        3'd1:    r_instr[31:24] <= mem_rdata;
                        3'd2:    r_instr[23:16] <= mem_rdata;
                        3'd3:    r_instr[15:8]  <= mem_rdata;
                        3'd4:    r_instr[7:0]   <= mem_rdata;
                        default: ;
                    endcase
                    if (r_cnt < 3'd3) begin
                        r_mem_addr <= r_pc + 32'(r_cnt) + 32'd1;
                    end
                    if (r_cnt == 3'd4) begin
                        r_cnt   <= 3'd0;
                        r_state <= FS_VALID;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                FS_VALID: begin
                    if (instr_ready) begin
                        r_pc       <= w_next_pc;
                        r_cnt      <= 3'd0;
                        r_mem_addr <= w_next_pc;
                        r_state    <= w_next_fault ? FS_FAULT : FS_FETCH;
                    end
                end
                FS_FAULT: ;
                default:  r_state <= FS_FAULT;
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign link_addr   = r_pc + 32'd4;
    assign instr_valid = (r_state == FS_VALID);
    assign fault       = (r_state == FS_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a byte-wide imem model
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        fault;

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (1024)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .pc           (pc),
        .link_addr    (link_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_target    (jr_target),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] link;
        int          issue;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] imem [0:1023];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= (mem_addr < 32'd1024) ? imem[mem_addr[9:0]] : 8'h00;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {imem[a[9:0]], imem[a[9:0] + 10'd1], imem[a[9:0] + 10'd2], imem[a[9:0] + 10'd3]};
    endfunction

    task automatic push_exp(input logic [31:0] p);
        exp_t e;
        e.instr = imem_word(p);
        e.pc    = p;
        e.link  = p + 32'd4;
        e.issue = cyc;
        exp_q.push_back(e);
    endtask

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check32("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("mon_instr", instr, e.instr);
                    check32("mon_pc", pc, e.pc);
                    check32("mon_link", link_addr, e.link);
                    check32("mon_latency", 32'(cyc - e.issue), 32'd5);
                end
            end
            prev_v = instr_valid;
        end
    end

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        if (!seen) check32({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic consume(input logic jr, input logic [31:0] jrt, input logic j,
                           input logic [25:0] ji, input logic br, input logic [15:0] bimm,
                           input logic [31:0] exp_pc, input logic exp_fault);
        jump_reg = jr; jr_target = jrt; jump = j; jump_index = ji;
        branch_taken = br; branch_imm = bimm; instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0; jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        check32("consume_valid_drop", {31'd0, instr_valid}, 32'd0);
        check32("consume_fault", {31'd0, fault}, {31'd0, exp_fault});
        if (!exp_fault) begin
            check32("consume_pc", pc, exp_pc);
            check32("consume_mem_addr", mem_addr, exp_pc);
            push_exp(exp_pc);
        end
    endtask

    initial begin
        logic [31:0] s_instr, s_pc, s_addr;
        for (int i = 0; i < 1024; i++) imem[i] = 8'((i * 37 + 11) & 255);
        imem[0] = 8'h0C; imem[1] = 8'h00; imem[2] = 8'h00; imem[3] = 8'h03;

        // 1: reset state and first fetch
        repeat (2) @(posedge clk);
        #1;
        check32("rst_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_fault", {31'd0, fault}, 32'd0);
        check32("rst_pc", pc, 32'h0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        push_exp(32'h0);
        reset = 1'b0;
        wait_valid("t1");
        check32("t1_instr", instr, 32'h0C00_0003);
        check32("t1_opcode", {26'd0, instr[31:26]}, {26'd0, OP_JAL});
        check32("t1_link", link_addr, 32'h4);

        // 2: jumps
        consume(1'b0, 32'h0, 1'b1, 26'h2, 1'b0, 16'h0, 32'h8, 1'b0);
        wait_valid("t2a");
        check32("t2_link", link_addr, 32'hC);
        consume(1'b0, 32'h0, 1'b1, 26'h3, 1'b0, 16'h0, 32'hC, 1'b0);
        wait_valid("t2b");
        consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 32'h10, 1'b0);
        wait_valid("t2c");

        // 3: branches
        consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFF, 32'h10, 1'b0);
        wait_valid("t3a");
        consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0002, 32'h1C, 1'b0);
        wait_valid("t3b");

        // 5: stall with redirect inputs toggling
        s_instr = instr; s_pc = pc; s_addr = mem_addr;
        for (int i = 0; i < 10; i++) begin
            jump = i[0]; jump_reg = i[1]; branch_taken = 1'b1;
            jr_target = $urandom; branch_imm = 16'($urandom);
            @(negedge clk);
            check32("t5_valid", {31'd0, instr_valid}, 32'd1);
            check32("t5_instr", instr, s_instr);
            check32("t5_pc", pc, s_pc);
            check32("t5_mem_addr", mem_addr, s_addr);
        end
        consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 32'h20, 1'b0);
        wait_valid("t5");

        // 4: jr priority, then misaligned jr faults
        consume(1'b1, 32'h20, 1'b1, 26'h5, 1'b1, 16'h0004, 32'h20, 1'b0);
        wait_valid("t4");
        consume(1'b1, 32'h22, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0, 1'b1);
        s_addr = mem_addr;
        repeat (8) begin
            @(negedge clk);
            check32("t4_fault_hold", {31'd0, fault}, 32'd1);
            check32("t4_valid_low", {31'd0, instr_valid}, 32'd0);
            check32("t4_mem_frozen", mem_addr, s_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check32("t4_fault_clear", {31'd0, fault}, 32'd0);

        // 6: reset mid-fetch at cnt=2, then refetch
        repeat (2) @(posedge clk);
        #1;
        check32("t6_partial_byte", {24'd0, instr[31:24]}, 32'h0C);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("t6_pc", pc, 32'h0);
        check32("t6_instr", instr, 32'h0);
        check32("t6_valid", {31'd0, instr_valid}, 32'd0);
        check32("t6_mem_addr", mem_addr, 32'h0);
        push_exp(32'h0);
        reset = 1'b0;
        wait_valid("t6");
        consume(1'b0, 32'h0, 1'b1, 26'h100, 1'b0, 16'h0, 32'h0, 1'b1);
        repeat (6) @(negedge clk);
        check32("t6_range_fault", {31'd0, fault}, 32'd1);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
